dma_engine: RTL
===============

DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 clk  in  1  clock; all state changes on its rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 dma_start  in  1  single-cycle command pulse from the controller.
REQ-004 dma_dir  in  1  0 = host->TPU (H2T), 1 = TPU->host (T2H).
REQ-005 dma_ub_addr  in  8  unified-buffer start word address.
REQ-006 dma_length  in  16  transfer length in elements.
REQ-007 dma_elem_sz  in  2  element size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = illegal.
REQ-008 dma_busy  out  1  engine occupied; this is the controller's stall input.
REQ-009 dma_done  out  1  one-cycle completion pulse.
REQ-010 dma_err  out  1  one-cycle error pulse, always coincident with dma_done.
REQ-011 host_rx_valid / host_rx_ready / host_rx_data  in/out/in  1/1/8  H2T byte stream.
REQ-012 host_tx_valid / host_tx_ready / host_tx_data  out/in/out  1/1/8  T2H byte stream.
REQ-013 ub_wr_en / ub_wr_addr / ub_wr_data  out  1/8/32  UB write port.
REQ-014 ub_rd_en / ub_rd_addr  out  1/8  UB read request.
REQ-015 ub_rd_data  in  32  UB read data, valid exactly 1 cycle after ub_rd_en.

Function
REQ-016 States: IDLE, H2T_RX, H2T_WR, T2H_RD, T2H_WAIT, T2H_TX, DONE.
REQ-017 Command capture in IDLE on dma_start:
- latch ub_addr; load byte count = dma_length << dma_elem_sz (18-bit, no overflow).
- next state is H2T_RX when dma_dir = 0, T2H_RD when dma_dir = 1.
REQ-018 Illegal command: dma_start with elem_sz = 3 or length = 0 goes to DONE; no UB or host traffic occurs; dma_err = 1 in the DONE cycle.
REQ-019 dma_start outside IDLE is ignored; the captured command is not disturbed.
REQ-020 dma_busy = 1 in every state except IDLE, i.e. from the cycle after the accepted start through the DONE cycle inclusive.
REQ-021 DONE lasts exactly 1 cycle and asserts dma_done; the next state is IDLE.
REQ-022 H2T byte acceptance:
- host_rx_ready = 1 only in H2T_RX.
- each handshake (valid & ready) stores the byte into lane (byte index mod 4) of a 32-bit pack register; lane 0 = bits [7:0] (little-endian).
REQ-023 H2T word completion:
- after the byte completing lane 3, or after the final byte, go to H2T_WR.
- H2T_WR asserts ub_wr_en for 1 cycle with the current word address.
- lanes not written for this word are 0.
- the pack register is cleared after the write.
REQ-024 H2T exit from H2T_WR: bytes remaining -> word address +1, back to H2T_RX; none remaining -> DONE.
REQ-025 T2H read:
- T2H_RD asserts ub_rd_en for 1 cycle at the current word address.
- T2H_WAIT captures ub_rd_data into the unpack register.
- then T2H_TX.
REQ-026 T2H_TX output:
- host_tx_valid = 1 with host_tx_data = the current lane, starting at lane 0.
- valid and data are held stable until host_tx_ready; each handshake advances one lane.
REQ-027 T2H_TX exit:
- after lane 3, or after the final byte: bytes remaining -> word address +1, T2H_RD; none remaining -> DONE.
- bytes beyond the transfer length are never presented.
REQ-028 Word address arithmetic is modulo 256; 0xFF wraps to 0x00 silently.
REQ-029 Stream stalls:
- host_rx_valid = 0 or host_tx_ready = 0 for any number of cycles holds state without loss or duplication.
- there is no timeout.
REQ-030 Port exclusivity: ub_wr_en and ub_rd_en are never asserted together; host_rx_ready and host_tx_valid are never asserted together.

Reset
REQ-031 Reset forces IDLE at any time, including mid-transfer; the partial transfer is abandoned and not resumed.
REQ-032 Reset values: every output = 0; all counters, address and data registers = 0.

Verification
REQ-033 H2T, elem_sz = 0, length = 6, ub_addr = 0x10, bytes 01..06 sent back-to-back:
- write 0x04030201 @0x10, then 0x00000605 @0x11.
- dma_done 1 cycle after the 2nd write; busy low the following cycle.
REQ-034 T2H, elem_sz = 1, length = 3, ub_addr = 0xFF, UB[0xFF] = 0xDDCCBBAA, UB[0x00] = 0x44332211, host_tx_ready always 1:
- read 0xFF, then 0x00 (wrap).
- stream out AA BB CC DD 11 22, then done.
REQ-035 T2H with host_tx_ready toggled 1/0 every cycle: the same 6 bytes appear with no repeats; host_tx_data is stable whenever valid = 1 and ready = 0.
REQ-036 Command variants:
- dma_start with elem_sz = 3 -> dma_done = dma_err = 1 one cycle after start; no ub_* or host_* activity.
- length = 0 -> same response.
- a second dma_start while busy -> ignored.
REQ-037 Reset mid-transfer: rst_n low during H2T after 2 bytes -> all outputs 0 immediately; a new command after reset completes normally from byte lane 0.

Source files
------------

// File: rtl/dma_engine.sv
// ---------------------------------------------------------------------------
// dma_engine
//
// Moves a block of elements between a host byte stream and the 32-bit
// unified buffer (UB).
//   H2T (dma_dir = 0): bytes from host_rx_* are packed little-endian into
//                      32-bit words and written to consecutive UB words.
//   T2H (dma_dir = 1): consecutive UB words are read and unpacked
//                      little-endian onto host_tx_*.
// The transfer size is dma_length elements of 1/2/4 bytes. A final partial
// word is zero-filled on writes. On reads, bytes past the end of the
// transfer are never presented.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   dma_start                        command pulse, accepted only when idle
//   dma_dir, dma_ub_addr,            command fields
//   dma_length, dma_elem_sz
//   dma_busy                         high in every state except idle
//   dma_done, dma_err                one-cycle completion / error pulses
//   host_rx_valid/ready/data         H2T byte stream (engine is the sink)
//   host_tx_valid/ready/data         T2H byte stream (engine is the source)
//   ub_wr_en/addr/data               UB write port
//   ub_rd_en/addr, ub_rd_data        UB read port, data one cycle after enable
// ---------------------------------------------------------------------------
module dma_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_start,
    input  logic        dma_dir,
    input  logic [7:0]  dma_ub_addr,
    input  logic [15:0] dma_length,
    input  logic [1:0]  dma_elem_sz,
    output logic        dma_busy,
    output logic        dma_done,
    output logic        dma_err,
    input  logic        host_rx_valid,
    output logic        host_rx_ready,
    input  logic [7:0]  host_rx_data,
    output logic        host_tx_valid,
    input  logic        host_tx_ready,
    output logic [7:0]  host_tx_data,
    output logic        ub_wr_en,
    output logic [7:0]  ub_wr_addr,
    output logic [31:0] ub_wr_data,
    output logic        ub_rd_en,
    output logic [7:0]  ub_rd_addr,
    input  logic [31:0] ub_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_H2T_RX,
        S_H2T_WR,
        S_T2H_RD,
        S_T2H_WAIT,
        S_T2H_TX,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  word_addr;
    logic [17:0] bytes_left;
    logic [1:0]  lane;
    logic [31:0] pack_word;
    logic [31:0] unpack_word;
    logic        err_flag;

    logic        cmd_ok;
    logic [17:0] byte_count;
    logic        rx_fire;
    logic        tx_fire;
    logic        last_byte;
    logic        word_end;

    // Widest case is 65535 elements of 4 bytes, which still fits in 18 bits.
    assign byte_count = {2'b00, dma_length} << dma_elem_sz;
    assign cmd_ok     = (dma_elem_sz != 2'd3) && (dma_length != 16'd0);

    assign rx_fire    = (state == S_H2T_RX) && host_rx_valid;
    assign tx_fire    = (state == S_T2H_TX) && host_tx_ready;
    assign last_byte  = (bytes_left == 18'd1);
    // The byte being transferred this cycle closes the current word.
    assign word_end   = (lane == 2'd3) || last_byte;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (dma_start) begin
                    if (!cmd_ok) begin
                        state_next = S_DONE;
                    end else if (dma_dir) begin
                        state_next = S_T2H_RD;
                    end else begin
                        state_next = S_H2T_RX;
                    end
                end
            end
            S_H2T_RX: begin
                if (rx_fire && word_end) begin
                    state_next = S_H2T_WR;
                end
            end
            S_H2T_WR: begin
                state_next = (bytes_left != 18'd0) ? S_H2T_RX : S_DONE;
            end
            S_T2H_RD:   state_next = S_T2H_WAIT;
            S_T2H_WAIT: state_next = S_T2H_TX;
            S_T2H_TX: begin
                if (tx_fire && word_end) begin
                    state_next = last_byte ? S_DONE : S_T2H_RD;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Command, address, count and pack/unpack registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_addr   <= 8'd0;
            bytes_left  <= 18'd0;
            lane        <= 2'd0;
            pack_word   <= 32'd0;
            unpack_word <= 32'd0;
            err_flag    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dma_start) begin
                        word_addr  <= dma_ub_addr;
                        bytes_left <= cmd_ok ? byte_count : 18'd0;
                        lane       <= 2'd0;
                        pack_word  <= 32'd0;
                        err_flag   <= !cmd_ok;
                    end
                end
                S_H2T_RX: begin
                    if (rx_fire) begin
                        pack_word[{lane, 3'b000} +: 8] <= host_rx_data;
                        lane       <= lane + 2'd1;
                        bytes_left <= bytes_left - 18'd1;
                    end
                end
                S_H2T_WR: begin
                    // Clearing here leaves unwritten lanes of a final partial word at zero.
                    pack_word <= 32'd0;
                    lane      <= 2'd0;
                    if (bytes_left != 18'd0) begin
                        word_addr <= word_addr + 8'd1;
                    end
                end
                S_T2H_WAIT: begin
                    unpack_word <= ub_rd_data;
                    lane        <= 2'd0;
                end
                S_T2H_TX: begin
                    if (tx_fire) begin
                        lane       <= lane + 2'd1;
                        bytes_left <= bytes_left - 18'd1;
                        if (word_end && !last_byte) begin
                            word_addr <= word_addr + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    err_flag <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: decoded from state so that everything is zero while idle or in reset.
    always_comb begin
        dma_busy      = 1'b0;
        dma_done      = 1'b0;
        dma_err       = 1'b0;
        host_rx_ready = 1'b0;
        host_tx_valid = 1'b0;
        host_tx_data  = 8'd0;
        ub_wr_en      = 1'b0;
        ub_wr_addr    = 8'd0;
        ub_wr_data    = 32'd0;
        ub_rd_en      = 1'b0;
        ub_rd_addr    = 8'd0;
        case (state)
            S_IDLE: begin
            end
            S_H2T_RX: begin
                dma_busy      = 1'b1;
                host_rx_ready = 1'b1;
            end
            S_H2T_WR: begin
                dma_busy   = 1'b1;
                ub_wr_en   = 1'b1;
                ub_wr_addr = word_addr;
                ub_wr_data = pack_word;
            end
            S_T2H_RD: begin
                dma_busy   = 1'b1;
                ub_rd_en   = 1'b1;
                ub_rd_addr = word_addr;
            end
            S_T2H_WAIT: begin
                dma_busy = 1'b1;
            end
            S_T2H_TX: begin
                dma_busy      = 1'b1;
                host_tx_valid = 1'b1;
                host_tx_data  = unpack_word[{lane, 3'b000} +: 8];
            end
            S_DONE: begin
                dma_busy = 1'b1;
                dma_done = 1'b1;
                dma_err  = err_flag;
            end
            default: begin
            end
        endcase
    end

endmodule
